// File: rtl/network_mul_arb_pkg.sv
// Shared widths, requester limit and round-robin pointer helper for network_mul_arb.
package network_mul_arb_pkg;

  localparam int DIN0_WIDTH = 14;
  localparam int DIN1_WIDTH = 16;
  localparam int DOUT_WIDTH = 30;
  localparam int MAX_REQ    = 8;

  function automatic int next_rr(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/network_mul_mul_14s_16s_30_1_1.sv
// Signed full-precision multiplier, purely combinational (registers live in the caller).
module network_mul_mul_14s_16s_30_1_1 #(
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 16,
  parameter int DOUT_WIDTH = 30
) (
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic [DOUT_WIDTH-1:0] dout
);

  logic signed [DOUT_WIDTH-1:0] a_ext;
  logic signed [DOUT_WIDTH-1:0] b_ext;

  // The product fits exactly in DOUT_WIDTH, so the truncated wide multiply is exact.
  assign a_ext = {{(DOUT_WIDTH-DIN0_WIDTH){din0[DIN0_WIDTH-1]}}, din0};
  assign b_ext = {{(DOUT_WIDTH-DIN1_WIDTH){din1[DIN1_WIDTH-1]}}, din1};
  assign dout  = a_ext * b_ext;

endmodule

// File: rtl/network_mul_rr_arb.sv
// Combinational round-robin pick starting at rr_ptr; no grant when en=0.
// NETWORK_MUL_ARB_PRIO0_EN: requester 0 wins outright and flags prio_hit so the pointer holds.
module network_mul_rr_arb
  import network_mul_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  input  logic                en,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_WIDTH-1:0] gnt_idx,
  output logic                prio_hit
);

  localparam int N = (NUM_REQ < MAX_REQ) ? NUM_REQ : MAX_REQ;

  logic found;
  int   idx;

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    prio_hit = 1'b0;
    found    = 1'b0;
    idx      = 0;
    if (en) begin
`ifdef NETWORK_MUL_ARB_PRIO0_EN
      if (req[0]) begin
        gnt[0]   = 1'b1;
        prio_hit = 1'b1;
        found    = 1'b1;
      end
`endif
      for (int k = 0; k < N; k++) begin
        idx = (int'(rr_ptr) + k) % N;
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gnt_idx  = ID_WIDTH'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/network_mul_arb.sv
// Round-robin shared 14x16 signed multiplier; 2-cycle accept-to-result latency.
// A held result (rsp_valid && !rsp_ready) freezes both stages and withholds grants.
// NETWORK_MUL_ARB_PRIO0_EN gives requester 0 strict priority (see network_mul_rr_arb).
module network_mul_arb
  import network_mul_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DIN0_WIDTH = network_mul_arb_pkg::DIN0_WIDTH,
  parameter int DIN1_WIDTH = network_mul_arb_pkg::DIN1_WIDTH,
  parameter int DOUT_WIDTH = network_mul_arb_pkg::DOUT_WIDTH,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DOUT_WIDTH-1:0]         rsp_dout
);

  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic                  s1_vld_q, s1_vld_d;
  logic [DIN0_WIDTH-1:0] s1_din0_q, s1_din0_d;
  logic [DIN1_WIDTH-1:0] s1_din1_q, s1_din1_d;
  logic [ID_WIDTH-1:0]   s1_id_q, s1_id_d;
  logic                  s2_vld_q, s2_vld_d;
  logic [DOUT_WIDTH-1:0] s2_dout_q, s2_dout_d;
  logic [ID_WIDTH-1:0]   s2_id_q, s2_id_d;

  logic                  adv;
  logic                  accept;
  logic [NUM_REQ-1:0]    gnt;
  logic [ID_WIDTH-1:0]   gnt_idx;
  logic                  prio_hit;
  logic [DIN0_WIDTH-1:0] din0_sel;
  logic [DIN1_WIDTH-1:0] din1_sel;
  logic [DOUT_WIDTH-1:0] prod;

  assign adv    = !(s2_vld_q && !rsp_ready);
  assign accept = |gnt;

  // Gating with reset keeps req_ready low while reset is asserted.
  network_mul_rr_arb #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req      (req_valid),
    .rr_ptr   (rr_ptr_q),
    .en       (adv && !ap_rst),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .prio_hit (prio_hit)
  );

  always_comb begin
    din0_sel = '0;
    din1_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        din0_sel = req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
        din1_sel = req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
      end
    end
  end

  network_mul_mul_14s_16s_30_1_1 #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .DOUT_WIDTH (DOUT_WIDTH)
  ) u_mul (
    .din0 (s1_din0_q),
    .din1 (s1_din1_q),
    .dout (prod)
  );

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    s1_vld_d  = s1_vld_q;
    s1_din0_d = s1_din0_q;
    s1_din1_d = s1_din1_q;
    s1_id_d   = s1_id_q;
    s2_vld_d  = s2_vld_q;
    s2_dout_d = s2_dout_q;
    s2_id_d   = s2_id_q;
    if (adv) begin
      s1_vld_d = accept;
      if (accept) begin
        s1_din0_d = din0_sel;
        s1_din1_d = din1_sel;
        s1_id_d   = gnt_idx;
        if (!prio_hit) begin
          rr_ptr_d = ID_WIDTH'(next_rr(int'(gnt_idx), NUM_REQ));
        end
      end
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_dout_d = prod;
        s2_id_d   = s1_id_q;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rr_ptr_q  <= '0;
      s1_vld_q  <= 1'b0;
      s1_din0_q <= '0;
      s1_din1_q <= '0;
      s1_id_q   <= '0;
      s2_vld_q  <= 1'b0;
      s2_dout_q <= '0;
      s2_id_q   <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      s1_vld_q  <= s1_vld_d;
      s1_din0_q <= s1_din0_d;
      s1_din1_q <= s1_din1_d;
      s1_id_q   <= s1_id_d;
      s2_vld_q  <= s2_vld_d;
      s2_dout_q <= s2_dout_d;
      s2_id_q   <= s2_id_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = s2_vld_q;
  assign rsp_id    = s2_id_q;
  assign rsp_dout  = s2_dout_q;

endmodule

// File: tb/tb_network_mul_arb.sv
// Scoreboard bench for network_mul_arb: directed grants checked per cycle, results checked by a monitor.
module tb_network_mul_arb;

  logic        ap_clk;
  logic        ap_rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [55:0] req_din0;
  logic [63:0] req_din1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [29:0] rsp_dout;

  network_mul_arb dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din0  (req_din0),
    .req_din1  (req_din1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_dout  (rsp_dout)
  );

  typedef struct {
    int     id;
    longint dout;
  } exp_t;

  exp_t   sb[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     op0 [4];
  int     op1 [4];
  longint exp_p [4];

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_op(input int i, input int a, input int b, input longint p);
    op0[i]   = a;
    op1[i]   = b;
    exp_p[i] = p;
  endtask

  // Entered just after a rising edge; checks grant (and optionally rsp_valid) mid-cycle.
  task automatic step(input logic [3:0] v, input logic [3:0] eg, input int erv, input logic rdy);
    exp_t e;
    req_valid = v;
    rsp_ready = rdy;
    for (int i = 0; i < 4; i++) begin
      req_din0[i*14 +: 14] = 14'(op0[i]);
      req_din1[i*16 +: 16] = 16'(op1[i]);
    end
    @(negedge ap_clk);
    chk("req_ready", longint'(req_ready), longint'(eg));
    if (erv >= 0) chk("rsp_valid", longint'(rsp_valid), longint'(erv));
    for (int i = 0; i < 4; i++) begin
      if (eg[i]) begin
        e.id   = i;
        e.dout = exp_p[i];
        sb.push_back(e);
      end
    end
    @(posedge ap_clk);
    #1;
  endtask

  always @(negedge ap_clk) begin
    if (!ap_rst && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        chk("rsp_id", longint'(rsp_id), longint'(sb[0].id));
        chk("rsp_dout", longint'($signed(rsp_dout)), sb[0].dout);
        if (rsp_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ap_rst    = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_din0  = '0;
    req_din1  = '0;
    for (int i = 0; i < 4; i++) set_op(i, 0, 0, 0);
    #3;
    chk("rst_req_ready", longint'(req_ready), 0);
    chk("rst_rsp_valid", longint'(rsp_valid), 0);
    chk("rst_rsp_id", longint'(rsp_id), 0);
    chk("rst_rsp_dout", longint'(rsp_dout), 0);
    @(posedge ap_clk);
    #1;
    ap_rst    = 1'b0;
    req_valid = 4'b0000;

    set_op(0, 100, 7, 700);
    set_op(1, -200, -300, 60000);
    set_op(2, 8191, -32768, -268402688);
    set_op(3, -8192, 32767, -268427264);

`ifdef NETWORK_MUL_ARB_PRIO0_EN
    step(4'b1111, 4'b0001, 0, 1'b1);
    step(4'b1111, 4'b0001, 0, 1'b1);
    step(4'b1111, 4'b0001, 1, 1'b1);
    step(4'b1111, 4'b0001, 1, 1'b1);
    step(4'b1110, 4'b0010, 1, 1'b1);
    step(4'b1100, 4'b0100, 1, 1'b1);
    step(4'b1000, 4'b1000, 1, 1'b1);
    step(4'b0000, 4'b0000, 1, 1'b1);
    step(4'b0000, 4'b0000, 1, 1'b1);
    step(4'b0000, 4'b0000, 0, 1'b1);
`else
    // All four continuously valid: grants rotate from pointer 0
    for (int c = 0; c < 8; c++) begin
      logic [3:0] g;
      g = 4'b0001 << (c % 4);
      step(4'b1111, g, (c < 2) ? 0 : 1, 1'b1);
    end
    step(4'b0000, 4'b0000, 1, 1'b1);
    step(4'b0000, 4'b0000, 1, 1'b1);
    step(4'b0000, 4'b0000, 0, 1'b1);

    // Single request, latency of two cycles
    set_op(0, 3, -5, -15);
    step(4'b0001, 4'b0001, 0, 1'b1);
    step(4'b0000, 4'b0000, 0, 1'b1);
    step(4'b0000, 4'b0000, 1, 1'b1);
    step(4'b0000, 4'b0000, 0, 1'b1);

    // Extreme operands
    set_op(1, -8192, -32768, 268435456);
    set_op(2, 8191, -32768, -268402688);
    step(4'b0010, 4'b0010, 0, 1'b1);
    step(4'b0100, 4'b0100, 0, 1'b1);
    step(4'b0000, 4'b0000, 1, 1'b1);
    step(4'b0000, 4'b0000, 1, 1'b1);
    step(4'b0000, 4'b0000, 0, 1'b1);

    // Backpressure: pointer at 3, stall cycles 3-6
    set_op(0, 12, -12, -144);
    set_op(1, -1, -1, 1);
    set_op(2, 5, 6, 30);
    set_op(3, 1000, 1000, 1000000);
    step(4'b1111, 4'b1000, 0, 1'b1);
    step(4'b0111, 4'b0001, 0, 1'b1);
    step(4'b0110, 4'b0010, 1, 1'b1);
    for (int c = 3; c <= 6; c++) step(4'b0100, 4'b0000, 1, 1'b0);
    step(4'b0100, 4'b0100, 1, 1'b1);
    step(4'b0000, 4'b0000, 1, 1'b1);
    step(4'b0000, 4'b0000, 1, 1'b1);
    step(4'b0000, 4'b0000, 0, 1'b1);

    // Reset with both stages full; pointer would otherwise be 1
    step(4'b1111, 4'b1000, 0, 1'b1);
    step(4'b0111, 4'b0001, 0, 1'b1);
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    #2;
    ap_rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", longint'(rsp_valid), 0);
    chk("midrst_req_ready", longint'(req_ready), 0);
    sb.delete();
    @(posedge ap_clk);
    #1;
    ap_rst    = 1'b0;
    rsp_ready = 1'b1;
    set_op(0, -7, 9, -63);
    step(4'b1111, 4'b0001, 0, 1'b1);
    step(4'b0000, 4'b0000, 0, 1'b1);
    step(4'b0000, 4'b0000, 1, 1'b1);
    step(4'b0000, 4'b0000, 0, 1'b1);
`endif

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge ap_clk);
    chk("sb_drained", longint'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
